// File: rtl/convolution_processor_differentiator.sv
// First-difference stage: recovers x[n] = s[n] - s[n-1] from a running-sum stream,
// one frame of frame_len samples per start, with a one-deep valid/ready output register.
module convolution_processor_differentiator #(
  parameter int unsigned DATA_WIDTH = 22,
  parameter int unsigned LEN_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  frame_len,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                state_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  count_q;
  logic [DATA_WIDTH-1:0] prev_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_valid_q;

  logic in_xfer;
  logic out_xfer;
  logic out_free;

  // The output slot is free when empty or being drained this cycle.
  assign out_free = !out_valid_q || out_ready;
  assign in_ready = (state_q == StRun) && (count_q < len_q) && out_free;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid_q && out_ready;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      len_q       <= '0;
      count_q     <= '0;
      prev_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            len_q   <= frame_len;
            count_q <= '0;
            prev_q  <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          if (in_xfer) begin
            out_data_q  <= in_data - prev_q;
            prev_q      <= in_data;
            out_valid_q <= 1'b1;
            count_q     <= count_q + LEN_WIDTH'(1);
          end else if (out_xfer) begin
            out_valid_q <= 1'b0;
          end
          // All samples taken and the last result leaves (or already left) the slot.
          if ((count_q == len_q) && out_free) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
